// File: rtl/chan_mux_seq_pkg.sv
// Shared definitions for the chan_mux_seq channel multiplexer.
// Holds the mode encodings and the select-width helper.
package chan_mux_seq_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Width of a channel index; a 1-bit minimum keeps degenerate sizes legal
  function automatic int sel_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/chan_mux_seq_rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from ptr+1 with wrap and
// returns the first requesting channel as one-hot, index and any-grant flag.
module rr_arbiter
  import chan_mux_seq_pkg::*;
#(
  parameter int N  = 8,
  parameter int PW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_grant
);

  int idx_s;

  // First requester after ptr wins; ptr itself is checked last
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx_s     = 0;
    for (int k = 1; k <= N; k++) begin
      idx_s = (int'(ptr) + k) % N;
      if (!any_grant && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        grant_idx    = idx_s[PW-1:0];
        any_grant    = 1'b1;
      end else begin
      end
    end
  end

endmodule

// File: rtl/chan_mux_seq.sv
// Registered N-channel valid/ready multiplexer with fixed-select and
// round-robin modes feeding a one-entry output register.
module chan_mux_seq
  import chan_mux_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0]    out_data_r;
  logic [SEL_W-1:0]    out_ch_r;
  logic                out_valid_r;
  logic [SEL_W-1:0]    ptr_r;

  logic                can_load_s;
  logic [CHANNELS-1:0] fix_grant_s;
  logic [SEL_W-1:0]    fix_idx_s;
  logic                fix_any_s;
  logic [CHANNELS-1:0] rr_grant_s;
  logic [SEL_W-1:0]    rr_idx_s;
  logic                rr_any_s;
  logic [CHANNELS-1:0] grant_s;
  logic [SEL_W-1:0]    grant_idx_s;
  logic                any_grant_s;
  logic                xfer_s;
  logic [WIDTH-1:0]    sel_data_s;

  rr_arbiter #(
    .N  (CHANNELS),
    .PW (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr_r),
    .grant     (rr_grant_s),
    .grant_idx (rr_idx_s),
    .any_grant (rr_any_s)
  );

  // Fixed-select grant; out-of-range select values match no channel
  always_comb begin
    fix_grant_s = '0;
    fix_idx_s   = '0;
    fix_any_s   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if ((sel == SEL_W'(i)) && in_valid[i]) begin
        fix_grant_s[i] = 1'b1;
        fix_idx_s      = SEL_W'(i);
        fix_any_s      = 1'b1;
      end else begin
      end
    end
  end

  // Pick the grant source for the current mode
  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    any_grant_s = 1'b0;
    case (mode)
      MODE_FIXED: begin
        grant_s     = fix_grant_s;
        grant_idx_s = fix_idx_s;
        any_grant_s = fix_any_s;
      end
      MODE_RR: begin
        grant_s     = rr_grant_s;
        grant_idx_s = rr_idx_s;
        any_grant_s = rr_any_s;
      end
      default: begin
        grant_s     = '0;
        grant_idx_s = '0;
        any_grant_s = 1'b0;
      end
    endcase
  end

  assign can_load_s = !out_valid_r || out_ready;
  assign xfer_s     = any_grant_s && can_load_s && !rst;
  assign in_ready   = rst ? '0 : (grant_s & {CHANNELS{can_load_s}});
  assign sel_data_s = in_data[int'(grant_idx_s)*WIDTH +: WIDTH];

  // Output register and round-robin pointer; a load may coincide with a drain
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r  <= '0;
      out_ch_r    <= '0;
      out_valid_r <= 1'b0;
      ptr_r       <= SEL_W'(CHANNELS - 1);
    end else if (xfer_s) begin
      out_data_r  <= sel_data_s;
      out_ch_r    <= grant_idx_s;
      out_valid_r <= 1'b1;
      if (mode == MODE_RR) begin
        ptr_r <= grant_idx_s;
      end else begin
        ptr_r <= ptr_r;
      end
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;
  assign out_valid = out_valid_r;

endmodule

// File: doc/chan_mux_seq.md
# chan_mux_seq

Parametrised, registered N-channel data multiplexer with valid/ready handshakes on every input and on the output. It supports two modes: fixed-select, where an external select picks the channel, and round-robin, where an internal arbiter scans the channels. It sits between the channel sources and a single downstream consumer. It is the clocked, width- and channel-generic successor to the team's combinational 8:1 single-bit mux.

## Interface
Parameters:
- WIDTH, 8, data bits per channel
- CHANNELS, 8, number of input channels (≥2)
- SEL_W, $clog2(CHANNELS), select/channel-index width (derived)

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  rising-edge clock
  - rst  in  1  synchronous, active-high reset
- Inputs:
  - in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
  - in_valid  in  CHANNELS  per-channel valid
  - in_ready  out  CHANNELS  per-channel ready; at most one bit high
  - mode  in  1  0 = FIXED, 1 = ROUND_ROBIN
  - sel  in  SEL_W  channel select, used in FIXED mode only
- Output:
  - out_data  out  WIDTH  registered data
  - out_ch  out  SEL_W  index of the channel that out_data came from
  - out_valid  out  1  output holds data
  - out_ready  in  1  consumer accepts

## Operation
- One-entry output register (out_data, out_ch, out_valid).
  - can_load = !out_valid || out_ready.
- Grant, combinational, one channel per cycle:
  - FIXED: grant = sel when in_valid[sel] and sel < CHANNELS. If sel ≥ CHANNELS, there is no grant and all in_ready are 0.
  - ROUND_ROBIN: grant = first channel with in_valid set, scanning upward from ptr+1 and wrapping at CHANNELS-1 → 0. No valid channel → no grant.
- in_ready[g] = can_load for the granted channel g; every other bit of in_ready is 0. in_ready may depend combinationally on in_valid, mode, sel and out_ready.
- Input transfer on channel g occurs when in_valid[g] && in_ready[g]. On that clock edge:
  - out_data ← in_data[g]
  - out_ch ← g
  - out_valid ← 1
  - in ROUND_ROBIN mode only, ptr ← g
- Output transfer occurs when out_valid && out_ready.
  - If there is no simultaneous input transfer, out_valid ← 0.
  - A simultaneous input transfer refills the register on the same edge.
- While out_valid && !out_ready, out_data and out_ch are held stable and all in_ready are 0.
- ptr is updated only on ROUND_ROBIN transfers. FIXED-mode traffic leaves ptr unchanged.
- A mode or sel change takes effect on the next grant evaluation. It never disturbs data already held in the output register.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_ch = 0, ptr = CHANNELS-1, so channel 0 has first priority after reset. in_ready is all 0 during the reset cycle.
- Reset mid-operation: held data is discarded and not presented. The first legal input transfer is in the cycle after rst deasserts.
- Latency: input accept at edge N → out_valid = 1 with that data after edge N.
- Throughput: one word per cycle while out_ready is held at 1.
- Round-robin fairness: with all channels valid and out_ready = 1, grants rotate 0,1,…,CHANNELS-1,0. No channel waits more than CHANNELS-1 transfers.
- Wrap-around: ptr = CHANNELS-1 → the scan starts at 0.
- Non-power-of-two CHANNELS: indices ≥ CHANNELS are never granted and never appear on out_ch.

## Structure
- Shared package:
  - mode constants MODE_FIXED = 1'b0 and MODE_RR = 1'b1
  - a clog2-based SEL_W helper
- Sub-module rr_arbiter (parameter N):
  - inputs: req[N], ptr
  - outputs: one-hot grant[N], encoded grant index, any-grant flag
  - purely combinational
  - ptr register stays in the parent
- Parent contains the grant-select logic, the input data mux (indexed part-select) and the output register.

## Test plan
- Reset, then FIXED, sel = 3, in_valid = 8'h08, in_data ch3 = 8'hA5, out_ready = 1 → in_ready = 8'h08; next cycle out_data = 8'hA5, out_ch = 3, out_valid = 1.
- ROUND_ROBIN, in_valid = 8'hFF, channel i data = i, out_ready = 1 for 10 cycles → out_ch sequence 0,1,2,3,4,5,6,7,0,1 with out_data = out_ch.
- Backpressure: out_valid = 1 holding 8'h11, out_ready = 0 for 3 cycles with new valid input → out_data stays 8'h11 and in_ready = 0 throughout. Raising out_ready → same-cycle reload, no bubble.
- Sparse RR: in_valid = 8'b1000_0010 after a grant to ch7 → next grant is ch1, then ch7; channels 0 and 2–6 are never granted.
- CHANNELS = 5: FIXED with sel = 6 and in_valid = 5'h1F → in_ready = 0 and out_valid stays 0. Mode switch to RR → grant ch0 next cycle.
- Mid-stream reset: assert rst for 1 cycle while out_valid = 1 → next cycle out_valid = 0 and out_data = 0. After rst deasserts, the first RR grant goes to ch0.
